// File: rtl/cdb_result_arbiter.sv
// Round-robin arbiter sharing the ROB write-back port among FU_NUM stations.
// Define CDB_ARB_PERF_EN to add saturating grant/stall counters.
module cdb_result_arbiter #(
  parameter int FU_NUM    = 8,
  parameter int WORD_SIZE = 32,
  parameter int RB_INDEX  = 4,
  localparam int FW = (FU_NUM > 1) ? $clog2(FU_NUM) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [FU_NUM-1:0]             valid_bus,
  input  logic [FU_NUM*WORD_SIZE-1:0]   data_bus,
  input  logic [FU_NUM*RB_INDEX-1:0]    RB_index_bus,
  input  logic                          rb_ready,
  output logic [FU_NUM-1:0]             reset_bus,
  output logic                          cdb_valid,
  output logic [WORD_SIZE-1:0]          cdb_data,
  output logic [RB_INDEX-1:0]           cdb_rb_index,
  output logic [FW-1:0]                 cdb_fu
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [31:0]                   perf_grants,
  output logic [31:0]                   perf_stalls
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

  state_t                state;
  logic [FW-1:0]         rr_ptr;
  logic [FW-1:0]         idx;
  logic [FW-1:0]         gnt_idx;
  logic [FW-1:0]         nxt_ptr;
  logic                  gnt_vld;
  logic                  free;
  logic [FU_NUM-1:0]     req;
  logic [FU_NUM-1:0]     gnt_oh;
  logic [WORD_SIZE-1:0]  gnt_data;
  logic [RB_INDEX-1:0]   gnt_tag;

  assign free = (state == IDLE) | (cdb_valid & rb_ready);

  // A station acked last cycle may still show valid; ignore it once.
  assign req = valid_bus & ~reset_bus;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < FU_NUM; k++) begin
      idx = FW'((int'(rr_ptr) + k) % FU_NUM);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    gnt_oh   = '0;
    gnt_data = '0;
    gnt_tag  = '0;
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
    for (int i = 0; i < FU_NUM; i++) begin
      if (gnt_idx == FW'(i)) begin
        gnt_data = data_bus[i*WORD_SIZE +: WORD_SIZE];
        gnt_tag  = RB_index_bus[i*RB_INDEX +: RB_INDEX];
      end
    end
  end

  assign nxt_ptr = (gnt_idx == FW'(FU_NUM-1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      reset_bus    <= '0;
      cdb_valid    <= 1'b0;
      cdb_data     <= '0;
      cdb_rb_index <= '0;
      cdb_fu       <= '0;
    end else if (free) begin
      if (gnt_vld) begin
        state        <= DRIVE;
        rr_ptr       <= nxt_ptr;
        reset_bus    <= gnt_oh;
        cdb_valid    <= 1'b1;
        cdb_data     <= gnt_data;
        cdb_rb_index <= gnt_tag;
        cdb_fu       <= gnt_idx;
      end else begin
        state     <= IDLE;
        reset_bus <= '0;
        cdb_valid <= 1'b0;
      end
    end else begin
      state     <= HOLD;
      reset_bus <= '0;
    end
  end

`ifdef CDB_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_grants <= '0;
      perf_stalls <= '0;
    end else begin
      if (free && gnt_vld && perf_grants != 32'hFFFF_FFFF)
        perf_grants <= perf_grants + 32'd1;
      if (cdb_valid && !rb_ready && perf_stalls != 32'hFFFF_FFFF)
        perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_result_arbiter.sv
// Randomized bench for cdb_result_arbiter with a behavioural reference model.
// Directed scenarios pin the model with literal expectations.
module tb_cdb_result_arbiter;
  localparam int N  = 8;
  localparam int W  = 32;
  localparam int T  = 4;
  localparam int FW = 3;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           rb_ready = 1'b0;
  logic [N-1:0]   valid_bus = '0;
  logic [N*W-1:0] data_bus = '0;
  logic [N*T-1:0] RB_index_bus = '0;
  logic [N-1:0]   reset_bus;
  logic           cdb_valid;
  logic [W-1:0]   cdb_data;
  logic [T-1:0]   cdb_rb_index;
  logic [FW-1:0]  cdb_fu;
`ifdef CDB_ARB_PERF_EN
  logic [31:0]    perf_grants;
  logic [31:0]    perf_stalls;
`endif

  int tests = 0;
  int fails = 0;

  cdb_result_arbiter dut (
    .clk(clk),
    .reset_n(reset_n),
    .valid_bus(valid_bus),
    .data_bus(data_bus),
    .RB_index_bus(RB_index_bus),
    .rb_ready(rb_ready),
    .reset_bus(reset_bus),
    .cdb_valid(cdb_valid),
    .cdb_data(cdb_data),
    .cdb_rb_index(cdb_rb_index),
    .cdb_fu(cdb_fu)
`ifdef CDB_ARB_PERF_EN
    ,
    .perf_grants(perf_grants),
    .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the CDB slot is a one-entry buffer; a new word may
  // enter when the slot is empty or being taken this cycle.
  bit          m_valid;
  logic [W-1:0] m_data;
  logic [T-1:0] m_tag;
  int          m_fu;
  int          m_ptr;
  int          m_last;
  int          mw;
  logic [N-1:0] m_ack;
  logic [31:0] m_grants;
  logic [31:0] m_stalls;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid = 0; m_data = '0; m_tag = '0; m_fu = 0;
      m_ptr = 0; m_last = -1; m_ack = '0;
      m_grants = '0; m_stalls = '0;
    end else begin
      mw = -1;
      if (m_valid && !rb_ready && m_stalls != 32'hFFFF_FFFF)
        m_stalls = m_stalls + 1;
      if (!m_valid || rb_ready) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (mw < 0 && valid_bus[i] && i != m_last) mw = i;
        end
        if (mw >= 0) begin
          m_valid = 1;
          m_data  = data_bus[mw*W +: W];
          m_tag   = RB_index_bus[mw*T +: T];
          m_fu    = mw;
          m_ptr   = (mw + 1) % N;
          if (m_grants != 32'hFFFF_FFFF) m_grants = m_grants + 1;
        end else begin
          m_valid = 0;
        end
      end
      m_last = mw;
      m_ack  = (mw >= 0) ? (N'(1) << mw) : '0;
    end
  end

  always @(negedge clk) begin
    chk("cdb_valid", cdb_valid, m_valid);
    chk("reset_bus", reset_bus, m_ack);
    chk("ack_onehot0", $onehot0(reset_bus), 1);
    if (m_valid) begin
      chk("cdb_data", cdb_data, m_data);
      chk("cdb_rb_index", cdb_rb_index, m_tag);
      chk("cdb_fu", cdb_fu, m_fu);
    end
`ifdef CDB_ARB_PERF_EN
    chk("perf_grants", perf_grants, m_grants);
    chk("perf_stalls", perf_stalls, m_stalls);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int i, input logic [W-1:0] d,
                        input logic [T-1:0] t);
    valid_bus[i] = 1'b1;
    data_bus[i*W +: W] = d;
    RB_index_bus[i*T +: T] = t;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    valid_bus = '0;
    rb_ready = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  bit [N-1:0] linger;
  int load;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_valid", cdb_valid, 0);
    chk("rst_data", cdb_data, 0);
    chk("rst_tag", cdb_rb_index, 0);
    chk("rst_fu", cdb_fu, 0);
    chk("rst_ack", reset_bus, 0);

    // single request
    set_fu(2, 32'h1234, 4'd5);
    tick();
    chk("s1_valid", cdb_valid, 1);
    chk("s1_data", cdb_data, 32'h1234);
    chk("s1_tag", cdb_rb_index, 5);
    chk("s1_fu", cdb_fu, 2);
    chk("s1_ack", reset_bus, 8'b0000_0100);
    valid_bus = '0;
    tick();
    chk("s1_idle", cdb_valid, 0);

    // all request: full rotation, no bubble
    do_reset();
    for (int i = 0; i < N; i++) set_fu(i, 32'h100 + i, T'(i));
    for (int i = 0; i < N; i++) begin
      tick();
      chk("s2_valid", cdb_valid, 1);
      chk("s2_fu", cdb_fu, i);
      chk("s2_ack", reset_bus, N'(1) << i);
      chk("s2_data", cdb_data, 32'h100 + i);
      valid_bus[i] = 1'b0;
    end
    tick();
    chk("s2_idle", cdb_valid, 0);

    // backpressure
    do_reset();
    set_fu(1, 32'hAAAA, 4'd1);
    tick();
    chk("s3_fu1", cdb_fu, 1);
    valid_bus = '0;
    set_fu(2, 32'hBBBB, 4'd2);
    rb_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("s3_hold_valid", cdb_valid, 1);
      chk("s3_hold_fu", cdb_fu, 1);
      chk("s3_hold_data", cdb_data, 32'hAAAA);
      chk("s3_hold_ack", reset_bus, 0);
    end
    rb_ready = 1'b1;
    tick();
    chk("s3_next_fu", cdb_fu, 2);
    chk("s3_next_ack", reset_bus, 8'b0000_0100);
    valid_bus = '0;
    tick();
    chk("s3_idle", cdb_valid, 0);
`ifdef CDB_ARB_PERF_EN
    chk("s3_perf_grants", perf_grants, 2);
    chk("s3_perf_stalls", perf_stalls, 3);
`endif

    // wrap from pointer 7
    do_reset();
    set_fu(6, 32'h66, 4'd6);
    tick();
    chk("s4_fu6", cdb_fu, 6);
    valid_bus = '0;
    tick();
    set_fu(0, 32'h10, 4'd0);
    set_fu(6, 32'h16, 4'd6);
    tick();
    chk("s4_wrap_fu", cdb_fu, 0);
    chk("s4_wrap_data", cdb_data, 32'h10);
    valid_bus[0] = 1'b0;
    tick();
    chk("s4_after_fu", cdb_fu, 6);
    valid_bus = '0;
    tick();

    // reset while holding
    do_reset();
    set_fu(5, 32'h55, 4'd5);
    tick();
    valid_bus = '0;
    rb_ready = 1'b0;
    tick();
    tick();
    chk("s5_held", cdb_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("s5_rst_valid", cdb_valid, 0);
    chk("s5_rst_ack", reset_bus, 0);
    set_fu(3, 32'h33, 4'd3);
    set_fu(7, 32'h77, 4'd7);
    rb_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    chk("s5_fu3", cdb_fu, 3);
    chk("s5_ack3", reset_bus, 8'b0000_1000);
    valid_bus = '0;
    tick();

    // randomized traffic with lingering valids and dropped requests
    do_reset();
    linger = '0;
    for (int c = 0; c < 3000; c++) begin
      load = (c < 1000) ? 20 : ((c < 2000) ? 90 : 50);
      for (int i = 0; i < N; i++) begin
        if (m_ack[i]) begin
          if ($urandom_range(2) == 0) linger[i] = 1'b1;
          else valid_bus[i] = 1'b0;
        end else if (linger[i]) begin
          linger[i] = 1'b0;
          valid_bus[i] = 1'b0;
        end else if (valid_bus[i]) begin
          if ($urandom_range(49) == 0) valid_bus[i] = 1'b0;
        end else if (int'($urandom_range(99)) < load) begin
          set_fu(i, $urandom, T'($urandom));
        end
      end
      rb_ready = ($urandom_range(9) < 7);
      tick();
    end
    valid_bus = '0;
    rb_ready = 1'b1;
    tick();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
